// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter that shares one uart_tx serializer among N_REQ byte streams.
// A grant lasts from the optional source-ID header to the tlast beat, or until an idle timeout.
module uart_tx_arbiter #(
    parameter int unsigned           N_REQ      = 4,
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           INSERT_ID  = 1,
    parameter logic [DATA_WIDTH-1:0] ID_BASE    = DATA_WIDTH'(8'hF0),
    parameter int unsigned           TIMEOUT    = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [N_REQ-1:0]            s_axis_tvalid,
    input  logic [N_REQ-1:0]            s_axis_tlast,
    output logic [N_REQ-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic [N_REQ-1:0]            grant,
    output logic                        active,
    output logic                        timeout_err
);

    localparam int unsigned PW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PW-1:0] LAST_INIT = PW'(N_REQ - 1);
    localparam logic [15:0]   TO_LAST   = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e                  state_q;
    logic [N_REQ-1:0]        grant_q;
    logic [PW-1:0]           gidx_q;
    logic [PW-1:0]           last_q;
    logic                    active_q;
    logic [DATA_WIDTH-1:0]   m_tdata_q;
    logic                    m_tvalid_q;
    logic                    m_tlast_q;
    logic                    timeout_err_q;
    logic [15:0]             cnt_q;

    logic                    reg_free;
    logic [PW-1:0]           sel_d;
    logic                    g_valid;
    logic                    g_last;
    logic [DATA_WIDTH-1:0]   g_data;

    // First valid requester after the previous owner, wrapping modulo N_REQ.
    function automatic logic [PW-1:0] rr_pick(input logic [N_REQ-1:0] v,
                                              input logic [PW-1:0]    last);
        int idx;
        rr_pick = last;
        for (int k = int'(N_REQ); k >= 1; k--) begin
            idx = (int'(last) + k) % int'(N_REQ);
            if (v[idx]) begin
                rr_pick = PW'(idx);
            end
        end
    endfunction

    assign reg_free = !m_tvalid_q || m_axis_tready;
    assign sel_d    = rr_pick(s_axis_tvalid, last_q);

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (grant_q[i]) begin
                g_valid = s_axis_tvalid[i];
                g_last  = s_axis_tlast[i];
                g_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Only the owner may push, and only into a register that is empty or draining this cycle.
    assign s_axis_tready = (state_q == DATA) ? (grant_q & {N_REQ{reg_free}}) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            gidx_q        <= '0;
            last_q        <= LAST_INIT;
            active_q      <= 1'b0;
            m_tdata_q     <= '0;
            m_tvalid_q    <= 1'b0;
            m_tlast_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            timeout_err_q <= 1'b0;
            if (m_tvalid_q && m_axis_tready) begin
                m_tvalid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (|s_axis_tvalid && reg_free) begin
                        grant_q  <= N_REQ'(1) << sel_d;
                        gidx_q   <= sel_d;
                        active_q <= 1'b1;
                        cnt_q    <= '0;
                        if (INSERT_ID != 0) begin
                            m_tdata_q  <= ID_BASE + DATA_WIDTH'(sel_d);
                            m_tlast_q  <= 1'b0;
                            m_tvalid_q <= 1'b1;
                            state_q    <= HDR;
                        end else begin
                            state_q    <= DATA;
                        end
                    end
                end

                HDR: begin
                    if (m_tvalid_q && m_axis_tready) begin
                        state_q <= DATA;
                        cnt_q   <= '0;
                    end
                end

                DATA: begin
                    if (g_valid && reg_free) begin
                        m_tdata_q  <= g_data;
                        m_tlast_q  <= g_last;
                        m_tvalid_q <= 1'b1;
                        if (g_last) begin
                            state_q  <= IDLE;
                            grant_q  <= '0;
                            active_q <= 1'b0;
                            last_q   <= gidx_q;
                        end
                    end
                    // A held valid (even when stalled downstream) is not idleness.
                    if (g_valid) begin
                        cnt_q <= '0;
                    end else if (TIMEOUT != 0) begin
                        if (cnt_q == TO_LAST) begin
                            state_q       <= IDLE;
                            grant_q       <= '0;
                            active_q      <= 1'b0;
                            last_q        <= gidx_q;
                            timeout_err_q <= 1'b1;
                            cnt_q         <= '0;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                end

                default: begin
                    state_q  <= IDLE;
                    grant_q  <= '0;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tlast_q;
    assign grant         = grant_q;
    assign active        = active_q;
    assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed table, hand-written corner sequences and randomized
// packet traffic checked against a queue-level round-robin reference model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [N-1:0]  gnt;
    } beat_t;

    typedef struct packed {
        logic [3:0]    req;
        logic [DW-1:0] b0;
        logic [DW-1:0] b1;
        logic [DW-1:0] hdr;
        logic [N-1:0]  gnt;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*DW-1:0] s_tdata;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tlast;
    logic [N-1:0]    s_tready;
    logic [DW-1:0]   m_tdata;
    logic            m_tvalid;
    logic            m_tready;
    logic            m_tlast;
    logic [N-1:0]    grant;
    logic            active;
    logic            timeout_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ(N), .DATA_WIDTH(DW), .INSERT_ID(1), .ID_BASE(8'hF0), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast),
        .grant(grant), .active(active), .timeout_err(timeout_err)
    );

    logic [DW:0]  srcq [N][$];
    beat_t        expq [$];
    vec_t         tbl [4];
    int           vec_cnt = 0;
    int           err_cnt = 0;
    int           rdy_mode = 0;
    logic         prev_stall = 1'b0;
    logic [DW:0]  prev_beat = '0;
    logic [N-1:0] prev_grant = '0;
    int           idle0 = 0;
    int           to_cnt = 0;
    int           idle_at_to = -1;
    logic [N-1:0] grant_at_to = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive_inputs();
        logic [DW:0] e;
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0) begin
                e = srcq[i][0];
                s_tvalid[i]         = 1'b1;
                s_tlast[i]          = e[DW];
                s_tdata[i*DW +: DW] = e[DW-1:0];
            end else begin
                s_tvalid[i]         = 1'b0;
                s_tlast[i]          = 1'b0;
                s_tdata[i*DW +: DW] = '0;
            end
        end
    endtask

    task automatic add_src(input int req, input logic [DW-1:0] d, input logic last);
        srcq[req].push_back({last, d});
    endtask

    task automatic add_exp(input logic [DW-1:0] d, input logic last, input int owner);
        beat_t b;
        b.data = d;
        b.last = last;
        b.gnt  = N'(1) << owner;
        expq.push_back(b);
    endtask

    // One clock: observe at the falling edge, update sources just after the rising edge.
    task automatic cyc();
        logic [N-1:0] hs;
        beat_t        e;
        @(negedge clk);
        hs = s_tvalid & s_tready;
        if (prev_stall)
            chk("stall_hold", {22'd0, m_tvalid, m_tlast, m_tdata}, {22'd0, 1'b1, prev_beat});
        if (m_tvalid && !m_tready)
            chk("sready_while_stalled", 32'(s_tready), 32'd0);
        if (grant != prev_grant && grant != '0)
            chk("gap_before_grant", 32'(prev_grant), 32'd0);
        if (timeout_err) begin
            to_cnt++;
            if (idle_at_to < 0) begin
                idle_at_to  = idle0;
                grant_at_to = grant;
            end
        end
        if (grant == 4'b0001 && !s_tvalid[0]) idle0++;
        if (m_tvalid && m_tready) begin
            if (expq.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL m_beat: got unexpected beat 0x%0h, want none", m_tdata);
            end else begin
                e = expq.pop_front();
                chk("m_beat", {23'd0, m_tlast, m_tdata}, {23'd0, e.last, e.data});
                if (!e.last) chk("grant_during_packet", 32'(grant), 32'(e.gnt));
            end
        end
        prev_stall = m_tvalid && !m_tready;
        prev_beat  = {m_tlast, m_tdata};
        prev_grant = grant;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) void'(srcq[i].pop_front());
        end
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ($urandom_range(0, 3) != 0);
            default: m_tready = 1'b0;
        endcase
        drive_inputs();
    endtask

    function automatic bit all_done();
        bit d;
        d = (expq.size() == 0) && !m_tvalid;
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() != 0) d = 1'b0;
        end
        return d;
    endfunction

    task automatic flush();
        expq.delete();
        for (int i = 0; i < N; i++) srcq[i].delete();
        drive_inputs();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (!all_done()) begin
            if (n == budget) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL drain_budget: %0d beats outstanding after %0d cycles, want 0",
                         expq.size(), budget);
                flush();
                return;
            end
            cyc();
            n++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        prev_stall = 1'b0;
        prev_grant = '0;
    endtask

    task automatic wait_beat(input logic [DW-1:0] d, input int budget, input string nm);
        int n;
        n = 0;
        while (!(m_tvalid && m_tdata == d)) begin
            if (n == budget) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL %s: beat 0x%0h never appeared within %0d cycles", nm, d, budget);
                return;
            end
            cyc();
            n++;
        end
    endtask

    // Reference: packet lists per requester, served in round-robin order among those with packets left.
    task automatic rand_round();
        logic [DW-1:0] pb [N][$];
        int            plen [N][$];
        int            rem [N];
        int            last_own;
        int            own;
        int            len;
        int            any;
        logic [DW-1:0] b;
        for (int i = 0; i < N; i++) begin
            rem[i] = $urandom_range(0, 3);
            for (int p = 0; p < rem[i]; p++) begin
                len = $urandom_range(1, 5);
                plen[i].push_back(len);
                for (int j = 0; j < len; j++) begin
                    b = DW'($urandom);
                    pb[i].push_back(b);
                    add_src(i, b, j == len - 1);
                end
            end
        end
        last_own = N - 1;
        any = 1;
        while (any != 0) begin
            any = 0;
            own = -1;
            for (int k = 1; k <= N; k++) begin
                if (own < 0 && rem[(last_own + k) % N] > 0) own = (last_own + k) % N;
            end
            if (own >= 0) begin
                any = 1;
                add_exp(DW'(32'hF0 + own), 1'b0, own);
                len = plen[own].pop_front();
                for (int j = 0; j < len; j++) add_exp(pb[own].pop_front(), j == len - 1, own);
                rem[own]--;
                last_own = own;
            end
        end
        drive_inputs();
        do_reset();
        to_cnt   = 0;
        rdy_mode = 1;
        drain(3000);
        rdy_mode = 0;
        chk("no_spurious_timeout", 32'(to_cnt), 32'd0);
    endtask

    initial begin
        tbl[0] = '{req: 4'd2, b0: 8'h41, b1: 8'h42, hdr: 8'hF2, gnt: 4'b0100};
        tbl[1] = '{req: 4'd0, b0: 8'h10, b1: 8'h11, hdr: 8'hF0, gnt: 4'b0001};
        tbl[2] = '{req: 4'd3, b0: 8'hAA, b1: 8'h55, hdr: 8'hF3, gnt: 4'b1000};
        tbl[3] = '{req: 4'd1, b0: 8'h00, b1: 8'hFF, hdr: 8'hF1, gnt: 4'b0010};

        // Reset state, with every requester asserting valid.
        rst_n    = 1'b0;
        m_tready = 1'b1;
        s_tvalid = '1;
        s_tlast  = '0;
        s_tdata  = 32'hDEADBEEF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_m_tlast", 32'(m_tlast), 32'd0);
        chk("rst_m_tdata", 32'(m_tdata), 32'd0);
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        @(posedge clk);
        #1;
        drive_inputs();
        rst_n = 1'b1;

        // Single-requester packets from the table.
        for (int t = 0; t < 4; t++) begin
            add_src(int'(tbl[t].req), tbl[t].b0, 1'b0);
            add_src(int'(tbl[t].req), tbl[t].b1, 1'b1);
            expq.push_back('{data: tbl[t].hdr, last: 1'b0, gnt: tbl[t].gnt});
            expq.push_back('{data: tbl[t].b0,  last: 1'b0, gnt: tbl[t].gnt});
            expq.push_back('{data: tbl[t].b1,  last: 1'b1, gnt: tbl[t].gnt});
            drive_inputs();
            drain(200);
        end

        // All four valid at reset release: order 0,1,2,3.
        for (int i = 0; i < N; i++) begin
            add_src(i, DW'(8'hA0 + i), 1'b0);
            add_src(i, DW'(8'hB0 + i), 1'b1);
        end
        add_exp(8'hF0, 0, 0); add_exp(8'hA0, 0, 0); add_exp(8'hB0, 1, 0);
        add_exp(8'hF1, 0, 1); add_exp(8'hA1, 0, 1); add_exp(8'hB1, 1, 1);
        add_exp(8'hF2, 0, 2); add_exp(8'hA2, 0, 2); add_exp(8'hB2, 1, 2);
        add_exp(8'hF3, 0, 3); add_exp(8'hA3, 0, 3); add_exp(8'hB3, 1, 3);
        drive_inputs();
        do_reset();
        drain(300);

        // Req 1 and req 3 both streaming: strict alternation 1,3,1,3.
        add_src(1, 8'h11, 0); add_src(1, 8'h12, 1); add_src(1, 8'h13, 1);
        add_src(3, 8'h31, 1); add_src(3, 8'h32, 0); add_src(3, 8'h33, 1);
        add_exp(8'hF1, 0, 1); add_exp(8'h11, 0, 1); add_exp(8'h12, 1, 1);
        add_exp(8'hF3, 0, 3); add_exp(8'h31, 1, 3);
        add_exp(8'hF1, 0, 1); add_exp(8'h13, 1, 1);
        add_exp(8'hF3, 0, 3); add_exp(8'h32, 0, 3); add_exp(8'h33, 1, 3);
        drive_inputs();
        drain(300);

        // Downstream stall of 20 cycles with a data beat held.
        add_src(0, 8'h61, 0); add_src(0, 8'h62, 0); add_src(0, 8'h63, 0); add_src(0, 8'h64, 1);
        add_exp(8'hF0, 0, 0); add_exp(8'h61, 0, 0); add_exp(8'h62, 0, 0);
        add_exp(8'h63, 0, 0); add_exp(8'h64, 1, 0);
        drive_inputs();
        wait_beat(8'h61, 50, "stall_setup");
        m_tready = 1'b0;
        rdy_mode = 2;
        repeat (20) cyc();
        rdy_mode = 0;
        drain(200);

        // Idle timeout: req 0 sends header + one byte without tlast, req 1 waits.
        add_src(0, 8'h5A, 0);
        add_src(1, 8'h77, 1);
        add_exp(8'hF0, 0, 0); add_exp(8'h5A, 0, 0);
        add_exp(8'hF1, 0, 1); add_exp(8'h77, 1, 1);
        drive_inputs();
        do_reset();
        idle0       = 0;
        to_cnt      = 0;
        idle_at_to  = -1;
        grant_at_to = 'x;
        drain(300);
        chk("timeout_idle_cycles", 32'(idle_at_to), 32'd16);
        chk("timeout_pulse_cycles", 32'(to_cnt), 32'd1);
        chk("grant_at_timeout", 32'(grant_at_to), 32'd0);

        // Reset while a data beat is held in the output register.
        add_src(2, 8'h21, 0); add_src(2, 8'h22, 0); add_src(2, 8'h23, 1);
        add_exp(8'hF2, 0, 2); add_exp(8'h21, 0, 2); add_exp(8'h22, 0, 2); add_exp(8'h23, 1, 2);
        drive_inputs();
        wait_beat(8'h21, 50, "reset_setup");
        m_tready = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("midrst_grant", 32'(grant), 32'd0);
        chk("midrst_s_tready", 32'(s_tready), 32'd0);
        chk("midrst_active", 32'(active), 32'd0);
        flush();
        add_src(0, 8'h01, 1);
        add_src(2, 8'h02, 1);
        add_exp(8'hF0, 0, 0); add_exp(8'h01, 1, 0);
        add_exp(8'hF2, 0, 2); add_exp(8'h02, 1, 2);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        m_tready   = 1'b1;
        prev_stall = 1'b0;
        prev_grant = '0;
        drive_inputs();
        drain(200);

        // Randomized traffic against the reference model.
        for (int r = 0; r < 4; r++) rand_round();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Packet-level round-robin arbiter that shares one uart_tx serializer among N_REQ AXI4-Stream byte sources (debug console, register dump, status reporter, etc.).
- Optionally prepends a source-ID byte to each packet.
- Holds the grant until the packet's tlast beat is accepted.
- Releases a stalled requester after a programmable idle timeout.
- Sits directly in front of uart_tx: m_axis_* connects to uart_tx s_axis_*.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 8, beat width; must match uart_tx DATA_WIDTH.
- INSERT_ID, 1, 1 = emit an ID header beat before each packet; 0 = no header.
- ID_BASE, 8'hF0, header value = ID_BASE + requester index (modulo 2^DATA_WIDTH).
- TIMEOUT, 1024, idle cycles mid-packet before forced release; 0 disables; max 65535.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  synchronous, active-low reset.
- s_axis_tdata  in  N_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tvalid  in  N_REQ  per-requester valid.
- s_axis_tlast  in  N_REQ  per-requester end of packet.
- s_axis_tready  out  N_REQ  per-requester ready.
- m_axis_tdata  out  DATA_WIDTH  to uart_tx.
- m_axis_tvalid  out  1  to uart_tx.
- m_axis_tready  in  1  from uart_tx.
- m_axis_tlast  out  1  end of packet (informational; uart_tx ignores it).
- grant  out  N_REQ  one-hot current owner; all zero when idle.
- active  out  1  a packet is in progress (HDR or DATA).
- timeout_err  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = IDLE; grant = 0; active = 0.
  - m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0.
  - s_axis_tready = 0; timeout_err = 0; timeout counter = 0.
  - RR pointer last = N_REQ-1, so requester 0 has first priority.
  - Reset mid-packet discards any held beat without completing it.
- Output register:
  - Single stage. Beat accepted downstream when m_axis_tvalid & m_axis_tready.
  - Register is "free" when !m_axis_tvalid | m_axis_tready.
  - m_axis_tvalid stays high, with data stable, until the beat is accepted.
- State IDLE:
  - If any s_axis_tvalid is high and the register is free, select the first valid index searching last+1, last+2, ... (mod N_REQ).
  - Next cycle: grant = onehot(sel), active = 1.
  - If INSERT_ID = 1: state -> HDR and the register loads ID_BASE+sel with tlast = 0, visible at t+1.
  - If INSERT_ID = 0: state -> DATA.
  - s_axis_tready = 0 for all requesters in IDLE.
- State HDR:
  - s_axis_tready = 0.
  - When the header is accepted, state -> DATA.
- State DATA:
  - s_axis_tready[g] = register free; all other ready bits are 0.
  - On s_axis_tvalid[g] & s_axis_tready[g], the register loads tdata[g] and tlast[g] on the next edge.
  - If that beat has tlast = 1: state -> IDLE, grant = 0, active = 0, last = g. The register still drains in IDLE.
  - The next arbitration can then happen no earlier than the cycle after the tlast beat is loaded. Minimum one-cycle gap between packets.
- Timeout (TIMEOUT > 0):
  - Counter clears on entry to DATA and on any cycle with s_axis_tvalid[g] = 1.
  - Otherwise it increments each DATA cycle.
  - When it reaches TIMEOUT: state -> IDLE, grant = 0, active = 0, last = g, timeout_err = 1 for one cycle, counter = 0.
  - No tlast is generated, so the downstream packet is truncated.
  - Non-granted requesters never affect the counter.
  - A beat and the timeout in the same cycle cannot occur, because a beat clears the counter.
- Fairness:
  - Requesters keep s_axis_tvalid held while waiting.
  - A requester that drops valid before grant is simply skipped.
  - Starvation bound: N_REQ-1 packets.
- Width rules:
  - Header addition wraps modulo 2^DATA_WIDTH.
  - RR pointer width = clog2(N_REQ).
  - Timeout counter is 16 bits.

Test Plan:
- Single requester, INSERT_ID=1, N_REQ=4, prescale=1, req 2 sends {0x41, 0x42 last} -> m beats 0xF2, 0x41, 0x42 (tlast on 0x42 only); grant=4'b0100 until 0x42 loaded; txd shows three frames.
- All four requesters valid at reset release, each with a 2-byte packet -> grant order 0,1,2,3; headers F0,F1,F2,F3; no interleaving within a packet; active low for ≥1 cycle between packets.
- Req 1 streams back-to-back packets while req 3 is also valid -> order 1,3,1,3 (round robin, no starvation).
- m_axis_tready held low 20 cycles during DATA -> m_axis_tdata/tvalid stable; s_axis_tready[g]=0; no beat lost or duplicated after release.
- TIMEOUT=16: req 0 sends header+1 byte (no tlast), then drops valid -> 16 idle cycles later timeout_err pulses for 1 cycle, grant=0, and pending req 1 is granted next (header 0xF1).
- rst_n asserted while in DATA with a beat held -> next cycle m_axis_tvalid=0, grant=0, s_axis_tready=0; after release, req 0 wins first.
